// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Central stall/flush sequencer for a five-stage MIPS pipeline.
//            Generates the load enables and bubble (flush) controls of the PC
//            and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
//            Four conditions are resolved, highest priority first:
//              1. precise exception flush from MEM
//              2. data-memory wait state in MEM
//              3. multi-cycle iterative divider occupying EX
//              4. load-use hazard between EX (load) and ID (consumer)
//            Only control is produced; no datapath value passes through.
//
// Ports    : clk            pipeline clock, rising edge
//            rst            asynchronous reset, active-high
//            ID_Rs_i        rs field of the instruction in ID
//            ID_Rt_i        rt field of the instruction in ID
//            ID_UsesRs_i    ID instruction reads rs
//            ID_UsesRt_i    ID instruction reads rt
//            EX_Rw_i        destination register of the EX instruction
//            EX_RfWr_i      EX instruction writes the register file
//            EX_IsLoad_i    EX instruction is a load
//            EX_IsDiv_i     EX instruction is DIV/DIVU
//            MEM_DmReq_i    MEM stage issues a data-memory access
//            MEM_DmAck_i    data memory completes the access this cycle
//            MEM_Exception_i exception on the instruction in MEM
//            PC_Wr_o        PC load enable
//            IFID_Wr_o .. MEMWB_Wr_o        pipeline register load enables
//            IFID_Flush_o .. MEMWB_Flush_o  load a bubble (overrides Wr)
//            Div_Start_o    one-cycle start pulse to the divider
//            Div_Busy_o     divider occupies EX (registered state)
//            Stall_Cnt_o    count of cycles with PC_Wr_o low
//
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int DIV_CYCLES = 32          // legal range 2..63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_Rs_i,
    input  logic [4:0]  ID_Rt_i,
    input  logic        ID_UsesRs_i,
    input  logic        ID_UsesRt_i,
    input  logic [4:0]  EX_Rw_i,
    input  logic        EX_RfWr_i,
    input  logic        EX_IsLoad_i,
    input  logic        EX_IsDiv_i,
    input  logic        MEM_DmReq_i,
    input  logic        MEM_DmAck_i,
    input  logic        MEM_Exception_i,
    output logic        PC_Wr_o,
    output logic        IFID_Wr_o,
    output logic        IDEX_Wr_o,
    output logic        EXMEM_Wr_o,
    output logic        MEMWB_Wr_o,
    output logic        IFID_Flush_o,
    output logic        IDEX_Flush_o,
    output logic        EXMEM_Flush_o,
    output logic        MEMWB_Flush_o,
    output logic        Div_Start_o,
    output logic        Div_Busy_o,
    output logic [31:0] Stall_Cnt_o
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [0:0] S_RUN      = 1'b0;
    localparam logic [0:0] S_DIV_BUSY = 1'b1;

    // Busy-phase length: the start cycle is itself a frozen cycle, so the
    // counter covers the remaining DIV_CYCLES-1 frozen cycles and then one
    // final div_cnt=0 cycle in which EX is released.
    localparam logic [5:0] C_DIV_LOAD = 6'(DIV_CYCLES - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [0:0]  state_q,     state_d;
    logic [5:0]  div_cnt_q,   div_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // ------------------------------------------------------------------
    // Condition decode
    // ------------------------------------------------------------------
    logic w_load_use;
    logic w_mem_wait;
    logic w_div_issue;      // divide sitting in EX, not yet started
    logic w_div_hold;       // divide in progress, result not ready yet

    always_comb begin
        // $zero is never a real producer, so a load into r0 cannot stall.
        w_load_use = EX_IsLoad_i && EX_RfWr_i && (EX_Rw_i != 5'd0) &&
                     ((ID_UsesRs_i && (ID_Rs_i == EX_Rw_i)) ||
                      (ID_UsesRt_i && (ID_Rt_i == EX_Rw_i)));
        w_mem_wait  = MEM_DmReq_i && !MEM_DmAck_i;
        w_div_issue = (state_q == S_RUN) && EX_IsDiv_i;
        w_div_hold  = (state_q == S_DIV_BUSY) && (div_cnt_q != 6'd0);
    end

    // ------------------------------------------------------------------
    // Output and next-state decode (priority ordered)
    // ------------------------------------------------------------------
    always_comb begin
        // Free-flowing pipeline unless a condition below claims control.
        PC_Wr_o       = 1'b1;
        IFID_Wr_o     = 1'b1;
        IDEX_Wr_o     = 1'b1;
        EXMEM_Wr_o    = 1'b1;
        MEMWB_Wr_o    = 1'b1;
        IFID_Flush_o  = 1'b0;
        IDEX_Flush_o  = 1'b0;
        EXMEM_Flush_o = 1'b0;
        MEMWB_Flush_o = 1'b0;
        Div_Start_o   = 1'b0;
        state_d       = state_q;
        div_cnt_d     = div_cnt_q;

        if (rst) begin
            // Hold every stage empty while reset is applied.
            PC_Wr_o       = 1'b0;
            IFID_Wr_o     = 1'b0;
            IDEX_Wr_o     = 1'b0;
            EXMEM_Wr_o    = 1'b0;
            MEMWB_Wr_o    = 1'b0;
            IFID_Flush_o  = 1'b1;
            IDEX_Flush_o  = 1'b1;
            EXMEM_Flush_o = 1'b1;
            MEMWB_Flush_o = 1'b1;
            state_d       = S_RUN;
            div_cnt_d     = 6'd0;
        end else if (MEM_Exception_i) begin
            // Squash everything younger than and including MEM; the PC
            // still loads so the exception vector enters fetch. Any divide
            // in flight is abandoned.
            IFID_Flush_o  = 1'b1;
            IDEX_Flush_o  = 1'b1;
            EXMEM_Flush_o = 1'b1;
            MEMWB_Flush_o = 1'b1;
            state_d       = S_RUN;
            div_cnt_d     = 6'd0;
        end else if (w_mem_wait) begin
            // Freeze PC..EX/MEM; MEM/WB receives a bubble each wait cycle.
            // The divider sequencer is frozen too, so a pending start is
            // simply re-evaluated once the wait clears.
            PC_Wr_o       = 1'b0;
            IFID_Wr_o     = 1'b0;
            IDEX_Wr_o     = 1'b0;
            EXMEM_Wr_o    = 1'b0;
            MEMWB_Flush_o = 1'b1;
        end else if (w_div_issue || w_div_hold) begin
            // EX is occupied by the divide: hold the front end, send a
            // bubble down into MEM, let the older MEM instruction retire.
            PC_Wr_o       = 1'b0;
            IFID_Wr_o     = 1'b0;
            IDEX_Wr_o     = 1'b0;
            EXMEM_Flush_o = 1'b1;
            if (w_div_issue) begin
                Div_Start_o = 1'b1;
                state_d     = S_DIV_BUSY;
                div_cnt_d   = C_DIV_LOAD;
            end else begin
                div_cnt_d   = div_cnt_q - 6'd1;
            end
        end else begin
            // Result-valid cycle of a divide: EX advances, back to RUN so a
            // following divide can issue on the very next cycle.
            if (state_q == S_DIV_BUSY) begin
                state_d = S_RUN;
            end
            if (w_load_use) begin
                // One bubble into ID/EX while the consumer waits in ID.
                PC_Wr_o      = 1'b0;
                IFID_Wr_o    = 1'b0;
                IDEX_Flush_o = 1'b1;
            end
        end

        stall_cnt_d = PC_Wr_o ? stall_cnt_q : (stall_cnt_q + 32'd1);
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RUN;
            div_cnt_q   <= 6'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Div_Busy_o  = (state_q == S_DIV_BUSY);
    assign Stall_Cnt_o = stall_cnt_q;

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage MIPS pipeline. It drives the write-enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves four conditions: load-use hazards, a multi-cycle iterative divider in EX, data-memory wait states in MEM, and precise exception flushes from MEM. It is pure control and never touches datapath values.

## Interface
- DIV_CYCLES, 32, divider latency in cycles from Div_Start to result valid; legal range 2..63.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- ID_Rs  in  5  rs field of the instruction in ID.
- ID_Rt  in  5  rt field of the instruction in ID.
- ID_UsesRs  in  1  ID instruction reads rs.
- ID_UsesRt  in  1  ID instruction reads rt.
- EX_Rw  in  5  destination register of the instruction in EX.
- EX_RfWr  in  1  EX instruction writes the register file.
- EX_IsLoad  in  1  EX instruction is a load.
- EX_IsDiv  in  1  EX instruction is DIV/DIVU.
- MEM_DmReq  in  1  MEM stage is issuing a data-memory access.
- MEM_DmAck  in  1  data memory completes the access this cycle.
- MEM_Exception  in  1  exception detected on the instruction in MEM.
- PC_Wr  out  1  PC load enable.
- IFID_Wr, IDEX_Wr, EXMEM_Wr, MEMWB_Wr  out  1 each  pipeline register load enables.
- IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush  out  1 each  load a bubble: Instr=0, RfWr=0. Flush overrides Wr.
- Div_Start  out  1  one-cycle start pulse to the divider.
- Div_Busy  out  1  high while state is DIV_BUSY.
- Stall_Cnt  out  32  performance counter of stalled cycles.

## Operation
- States: RUN and DIV_BUSY. Down-counter div_cnt is 6 bits.
- Priority, highest first: exception, then mem-wait, then div, then load-use. Only the highest active condition drives the outputs.
- Default with no condition active: every *_Wr=1, every *_Flush=0.
- Exception (MEM_Exception=1):
  - IFID_Flush, IDEX_Flush, EXMEM_Flush and MEMWB_Flush are all 1. PC_Wr=1, so the vector is loaded by the PC mux.
  - The state is forced to RUN and div_cnt cleared, which aborts any divide.
  - Div_Start=0.
- Mem-wait (MEM_DmReq=1 and MEM_DmAck=0):
  - PC_Wr, IFID_Wr, IDEX_Wr and EXMEM_Wr are 0. MEMWB_Flush=1.
  - div_cnt holds and the state holds.
  - Div_Start=0; a start is deferred until the wait clears.
- Div, state RUN with EX_IsDiv=1:
  - Div_Start=1.
  - PC_Wr, IFID_Wr and IDEX_Wr are 0. EXMEM_Flush=1, MEMWB_Wr=1.
  - Next state DIV_BUSY with div_cnt=DIV_CYCLES-1.
- Div, state DIV_BUSY with div_cnt≠0: same stall outputs as the start cycle, with Div_Start=0; div_cnt decrements.
- Div, state DIV_BUSY with div_cnt=0:
  - No div stall; the divide result is valid and EX advances.
  - Next state RUN.
  - Load-use cannot coincide, because EX holds the divide.
- Load-use:
  - Condition: EX_IsLoad, EX_RfWr and EX_Rw≠0 are all true, and either (ID_UsesRs and ID_Rs==EX_Rw) or (ID_UsesRt and ID_Rt==EX_Rw).
  - Response: PC_Wr=0, IFID_Wr=0, IDEX_Flush=1. Other stages advance.
  - All other RAW hazards are resolved by forwarding and are not handled here.
- Stall_Cnt increments by 1 in every non-reset cycle with PC_Wr=0. It wraps from 0xFFFFFFFF to 0.

## Timing
- While rst=1:
  - State=RUN, div_cnt=0, Stall_Cnt=0.
  - All *_Wr=0, all *_Flush=1, Div_Start=0, Div_Busy=0.
- First cycle after rst deasserts: default outputs, unless an input condition is active.
- All *_Wr, *_Flush and Div_Start outputs are combinational from the current state and inputs; there is zero-cycle latency into the pipeline registers.
- Divide latency, uninterrupted: EX is frozen for exactly DIV_CYCLES cycles (the start cycle plus DIV_CYCLES-1 busy cycles). EX advances on the edge that ends the div_cnt=0 cycle.
- A mem-wait during DIV_BUSY extends the freeze one cycle per wait cycle, including when div_cnt=0.
- Load-use costs exactly 1 bubble cycle.
- Back-to-back divides: the second divide's Div_Start fires in the first RUN cycle after the first divide completes.
- Div_Busy is registered: 1 from the cycle after Div_Start through the div_cnt=0 cycle.

## Test plan
- Reset: assert rst mid-DIV_BUSY (div_cnt=10) → all Wr=0, all Flush=1, Stall_Cnt=0. After release, state=RUN and default outputs.
- Load-use: EX_IsLoad=1, EX_RfWr=1, EX_Rw=5, ID_Rt=5, ID_UsesRt=1 → one cycle of PC_Wr=0, IFID_Wr=0, IDEX_Flush=1. Repeating with EX_Rw=0 gives no stall.
- Divide, DIV_CYCLES=32: EX_IsDiv=1 at cycle 0 →
  - Div_Start high at cycle 0 only.
  - PC_Wr=0 for cycles 0..31; EX advances at the end of cycle 32.
  - Stall_Cnt=32.
- Mem-wait inside divide: MEM_DmReq=1 with MEM_DmAck=0 for 3 cycles at div_cnt=0 → MEMWB_Flush=1 and EXMEM_Wr=0 for 3 cycles. EX advances 3 cycles later than in the uninterrupted case.
- Exception during divide: MEM_Exception=1 at div_cnt=20 → all four Flush outputs=1 and PC_Wr=1. Next cycle state=RUN, Div_Busy=0.
- Priority: exception, mem-wait and load-use asserted together → exception outputs only. With exception removed → mem-wait outputs only.
